// File: rtl/uart_rx_fifo_if.sv
// Frame-in / show-ahead-read-out bundle for uart_rx_fifo.
// The slave modport is the FIFO side; the master modport is the receiver-plus-host side.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              parity_error;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output rx_data, rx_done, parity_error, rd_ready,
        input  rd_data, rd_perr, rd_valid
    );

    modport slave (
        input  rx_data, rx_done, parity_error, rd_ready,
        output rd_data, rd_perr, rd_valid
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with show-ahead read port, rts_n hysteresis and sticky overflow.
// Optional UART_RX_FIFO_DROP_PERR_EN: discard parity-errored frames and flag them on perr_drop.
module uart_rx_fifo #(
    parameter int  DATA_W    = 8,
    parameter int  DEPTH     = 16,
    parameter int  AFULL_LVL = 12,
    parameter int  RTS_HYST  = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus,
    output logic [AW:0]   count,
    output logic          rts_n,
    output logic          overflow,
    input  logic          overflow_clr
`ifdef UART_RX_FIFO_DROP_PERR_EN
    ,
    output logic          perr_drop
`endif
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0] RESUME_C = (AW+1)'(AFULL_LVL - RTS_HYST);

`ifdef UART_RX_FIFO_DROP_PERR_EN
    localparam int EW = DATA_W;
`else
    localparam int EW = DATA_W + 1;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic [EW-1:0] wr_entry;
    logic          frame_ok;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop_full;

`ifdef UART_RX_FIFO_DROP_PERR_EN
    assign frame_ok     = bus.rx_done & ~bus.parity_error;
    assign wr_entry     = bus.rx_data;
    assign bus.rd_data  = mem[rd_ptr];
    assign bus.rd_perr  = 1'b0;
`else
    assign frame_ok     = bus.rx_done;
    assign wr_entry     = {bus.parity_error, bus.rx_data};
    assign bus.rd_data  = mem[rd_ptr][DATA_W-1:0];
    assign bus.rd_perr  = mem[rd_ptr][DATA_W];
`endif

    assign bus.rd_valid = (count != '0);
    assign full         = (count == DEPTH_C);
    assign pop          = bus.rd_valid & bus.rd_ready;
    // A full FIFO still takes a frame when the head leaves in the same cycle.
    assign push         = frame_ok & (~full | pop);
    assign drop_full    = frame_ok & full & ~pop;
    assign count_next   = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rts_n    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            // Between the two thresholds rts_n keeps its last value.
            if (count_next >= AFULL_C) begin
                rts_n <= 1'b1;
            end else if (count_next <= RESUME_C) begin
                rts_n <= 1'b0;
            end
            if (drop_full) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_DROP_PERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_drop <= 1'b0;
        end else if (bus.rx_done & bus.parity_error) begin
            perr_drop <= 1'b1;
        end else if (overflow_clr) begin
            perr_drop <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are queued as they are accepted and
// compared against the head whenever the host pops.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 12;
    localparam int RESUME = 8;

    logic       clk;
    logic       reset;
    logic [4:0] count;
    logic       rts_n;
    logic       overflow;
    logic       overflow_clr;
`ifdef UART_RX_FIFO_DROP_PERR_EN
    logic       perr_drop;
    logic       m_pdrop;
`endif

    uart_rx_fifo_if #(.DATA_W(DATA_W)) bus_if ();

    uart_rx_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL), .RTS_HYST(AFULL - RESUME)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if.slave),
        .count        (count),
        .rts_n        (rts_n),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef UART_RX_FIFO_DROP_PERR_EN
        ,
        .perr_drop    (perr_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W:0] sb_q[$];
    logic            m_ovf;
    logic            m_rts;
    int              checks;
    int              errors;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input logic done, input logic [DATA_W-1:0] data,
                                 input logic perr, input logic rdy, input logic clr);
        logic do_pop, do_push, ok, full;
        bus_if.rx_done      = done;
        bus_if.rx_data      = data;
        bus_if.parity_error = perr;
        bus_if.rd_ready     = rdy;
        overflow_clr        = clr;
        #1;
        checkOutput("rd_valid", 32'(bus_if.rd_valid), 32'(sb_q.size() != 0));
        do_pop = (sb_q.size() != 0) && rdy;
        if (do_pop) begin
            checkOutput("rd_data", 32'(bus_if.rd_data), 32'(sb_q[0][DATA_W-1:0]));
            checkOutput("rd_perr", 32'(bus_if.rd_perr), 32'(sb_q[0][DATA_W]));
        end
`ifdef UART_RX_FIFO_DROP_PERR_EN
        ok = done && !perr;
        if (done && perr) m_pdrop = 1'b1;
        else if (clr) m_pdrop = 1'b0;
`else
        ok = done;
`endif
        full    = (sb_q.size() == DEPTH);
        do_push = ok && (!full || do_pop);
        if (do_pop) void'(sb_q.pop_front());
        if (do_push) sb_q.push_back({perr, data});
        if (ok && full && !do_pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (sb_q.size() >= AFULL) m_rts = 1'b1;
        else if (sb_q.size() <= RESUME) m_rts = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("count", 32'(count), 32'(sb_q.size()));
        checkOutput("rts_n", 32'(rts_n), 32'(m_rts));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_DROP_PERR_EN
        checkOutput("perr_drop", 32'(perr_drop), 32'(m_pdrop));
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && sb_q.size() != 0; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ovf  = 1'b0;
        m_rts  = 1'b1;
`ifdef UART_RX_FIFO_DROP_PERR_EN
        m_pdrop = 1'b0;
`endif
        reset               = 1'b1;
        bus_if.rx_done      = 1'b0;
        bus_if.rx_data      = '0;
        bus_if.parity_error = 1'b0;
        bus_if.rd_ready     = 1'b0;
        overflow_clr        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_valid", 32'(bus_if.rd_valid), 32'd0);
        checkOutput("rst_rts_n", 32'(rts_n), 32'd1);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] three frames then read back");
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        bus_if.rx_done = 1'b0;
        #1;
        checkOutput("t1_head", 32'(bus_if.rd_data), 32'h11);
        drain();

        $display("[TB] rts_n hysteresis");
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("t2_rts_high", 32'(rts_n), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_rts_hold", 32'(rts_n), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_rts_low", 32'(rts_n), 32'd0);
        drain();

        $display("[TB] overflow and full push-with-pop");
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("t3_count", 32'(count), 32'd16);
        checkOutput("t3_overflow", 32'(overflow), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_ovf_clr", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_count", 32'(count), 32'd16);
        drain();

        $display("[TB] interleaved traffic across pointer wrap");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, (i % 3) != 0, 1'b0);
        drain();

        $display("[TB] parity-errored frame");
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_DROP_PERR_EN
        checkOutput("t6_count", 32'(count), 32'd0);
        checkOutput("t6_perr_drop", 32'(perr_drop), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
`else
        bus_if.rx_done = 1'b0;
        #1;
        checkOutput("t6_data", 32'(bus_if.rd_data), 32'hA5);
        checkOutput("t6_perr", 32'(bus_if.rd_perr), 32'd1);
        drain();
`endif

        $display("[TB] asynchronous reset with data buffered");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        bus_if.rx_done = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_count", 32'(count), 32'd0);
        checkOutput("ar_valid", 32'(bus_if.rd_valid), 32'd0);
        checkOutput("ar_rts_n", 32'(rts_n), 32'd1);
        sb_q.delete();
        m_ovf = 1'b0;
        m_rts = 1'b1;
`ifdef UART_RX_FIFO_DROP_PERR_EN
        m_pdrop = 1'b0;
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
